key_matrix_scan: RTL and testbench
==================================

// Module: key_matrix_scan
// PURPOSE
//   Scans a 4x4 active-low key matrix for operator input on the front panel.
//   It drives one column low at a time, rotating 1110->1101->1011->0111, and reads the four pulled-up rows.
//   It debounces a press and reports a 4-bit key code with a one-cycle valid strobe.
//   It is the input-side counterpart of the multiplexed seven-segment driver and shares the same board-level scan scheme.
// PARAMETERS
//   SCAN_DIV        100000  clk cycles per scan tick; legal range >= 2
//   DEBOUNCE_TICKS  4       consecutive matching tick samples needed to accept a press or a release; legal range >= 1
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   key_row    in   4  matrix rows, active-low, asynchronous to clk
//   key_col    out  4  column drive, exactly one bit low
//   key_code   out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}
//   key_valid  out  1  one-cycle pulse when key_code is updated
//   key_down   out  1  high while the accepted key is still held
// BEHAVIOUR
// - One clock domain: clk. Reset is synchronous and active-high on rst; every register below resets on it.
// - Reset values: key_col=4'b1110, key_code=0, key_valid=0, key_down=0, state=SCAN.
//   Prescaler, debounce counter and synchronizer flops are all cleared.
// - Row synchronizer: key_row passes through 2 flops before any use; sync reset value is 4'b1111.
// - Scan tick: prescaler counts 0..SCAN_DIV-1 and wraps; tick is high for one cycle at count SCAN_DIV-1.
//   All FSM decisions happen only on tick cycles.
// - col_idx: index of the low bit of key_col (1110->0 ... 0111->3).
// - row_idx: lowest-numbered low row; if several rows are low, the lowest index wins.
// - FSM state SCAN:
//   - tick with synced rows == 4'b1111: rotate key_col left by one (0111 wraps to 1110).
//   - tick with any row low: latch row_idx and col_idx, set deb_cnt=1, hold key_col.
//     If DEBOUNCE_TICKS==1, accept immediately (see ACCEPT); otherwise go to DEBOUNCE.
// - FSM state DEBOUNCE (key_col frozen):
//   - tick with row[row_idx] low: deb_cnt+1; on reaching DEBOUNCE_TICKS -> ACCEPT.
//   - tick with row[row_idx] high: abort, rotate key_col, go to SCAN. No strobe.
// - ACCEPT: on that same tick edge, key_code <= {row_idx, col_idx}, key_valid=1 for exactly one clk, key_down=1, deb_cnt=0, go to HELD.
// - FSM state HELD (key_col frozen):
//   - tick with row[row_idx] high: deb_cnt+1; a tick with it low clears deb_cnt.
//   - deb_cnt reaching DEBOUNCE_TICKS: key_down=0, rotate key_col, go to SCAN.
// - Other keys pressed during DEBOUNCE/HELD are ignored (no rollover).
// - key_code holds its value until the next accept; it is not cleared on release.
// - Latency: key_valid rises 1 clk after the DEBOUNCE_TICKS-th consecutive matching tick.
// - Reset asserted mid-debounce or mid-hold: return to SCAN, key_col=1110, no pulse emitted.
// - deb_cnt width: $clog2(DEBOUNCE_TICKS+1); it saturates and never wraps.
// STRUCTURE
// - key_defs.vh (shared include):
//   - FSM state encodings SCAN/DEBOUNCE/HELD;
//   - COL_RESET=4'b1110 constant;
//   - ROW_IDLE=4'b1111 constant.
// - One sub-module: scan_tick_gen (SCAN_DIV prescaler, outputs tick).
//   It is reusable by the seven-segment driver. All other logic is inline.
// TESTING (sim params SCAN_DIV=4, DEBOUNCE_TICKS=3)
// 1 Reset, rows idle 1111 for 20 ticks -> key_col cycles 1110,1101,1011,0111,1110...; key_valid never 1.
// 2 Row1 low while col 2 is driven, held 10 ticks -> exactly one key_valid pulse, key_code=4'h6, key_down=1.
//   key_col stays 1011 until release.
// 3 Bounce: row0 low for 1 tick then high, at col 0 -> no key_valid; scanning resumes with key_col=1101.
// 4 Release: after case 2, row1 high with a 1-tick glitch low, then high 3 ticks -> key_down falls only after 3 clean ticks.
//   key_code stays 4'h6.
// 5 Rows 0 and 3 both low at col 3 -> key_code=4'h3 (lowest row wins).
// 6 rst pulsed during DEBOUNCE -> next clk key_col=1110, key_down=0, no key_valid afterwards.

Source files
------------

// File: rtl/key_matrix_scan_pkg.sv
// ---------------------------------------------------------------------------
// key_matrix_scan_pkg
//
// Purpose:
//   Shared definitions for the 4x4 key matrix scanner: FSM state encoding,
//   idle/reset constants for the column drive and row inputs, and small
//   helper functions that map between one-cold column/row vectors and
//   2-bit indices.
//
// Contents:
//   scan_state_t    SCAN / DEBOUNCE / HELD
//   COL_RESET       column drive pattern after reset (column 0 low)
//   ROW_IDLE        row pattern with no key pressed (all pulled up)
//   rotate_col()    advance the one-cold column drive to the next column
//   col_index()     index of the low bit in a one-cold column vector
//   lowest_low_row  index of the lowest-numbered low row
// ---------------------------------------------------------------------------
package key_matrix_scan_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'b1111;

    // Rotate left by one: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] rotate_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    // The column drive is always one-cold; any other pattern maps to 0.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Priority encoder on active-low rows; the lowest index wins when
    // several rows are pulled low by the same column.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        casez (rows)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/key_matrix_scan_scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
//
// Purpose:
//   Free-running prescaler producing a one-cycle scan tick every SCAN_DIV
//   clock cycles. Shared with the multiplexed seven-segment driver so both
//   panels step at the same rate.
//
// Parameters:
//   SCAN_DIV  clk cycles per tick, must be >= 2
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high; clears the prescaler
//   tick  out  high for one clk while the prescaler sits at SCAN_DIV-1
// ---------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/key_matrix_scan.sv
// ---------------------------------------------------------------------------
// key_matrix_scan
//
// Purpose:
//   Scans a 4x4 active-low key matrix. One column is driven low at a time
//   and the four pulled-up rows are read back. A press is debounced over
//   DEBOUNCE_TICKS scan ticks and then reported as a 4-bit key code with a
//   one-cycle valid strobe; the release is debounced the same way before
//   scanning resumes. Only one key is tracked at a time (no rollover).
//
// Parameters:
//   SCAN_DIV        clk cycles per scan tick, >= 2
//   DEBOUNCE_TICKS  consecutive matching tick samples to accept press or
//                   release, >= 1
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   key_row    in   [3:0] matrix rows, active-low, asynchronous to clk
//   key_col    out  [3:0] column drive, exactly one bit low
//   key_code   out  [3:0] last accepted key {row_idx, col_idx}
//   key_valid  out  one-cycle pulse when key_code is updated
//   key_down   out  high while the accepted key is still held
// ---------------------------------------------------------------------------
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_TICKS);
    localparam bit ACCEPT_ON_FIRST = (DEBOUNCE_TICKS == 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic             tick;
    scan_state_t      state;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_inc;
    logic             tracked_low;
    logic [1:0]       hit_row;
    logic [1:0]       hit_col;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer; resets to the idle (no key) pattern so the
    // FSM never sees a phantom press coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= ROW_IDLE;
            row_sync <= ROW_IDLE;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    // Saturating increment keeps the counter from wrapping back to zero.
    always_comb begin
        deb_inc     = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DEB_W'(1);
        tracked_low = ~row_sync[row_idx];
        hit_row     = lowest_low_row(row_sync);
        hit_col     = col_index(key_col);
    end

    // Scan / debounce / hold controller. Every decision is taken on a scan
    // tick; between ticks only the valid strobe is cleared. The column is
    // frozen while a key is being debounced or held so the same key stays
    // connected to its row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            key_col   <= COL_RESET;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_sync == ROW_IDLE) begin
                            key_col <= rotate_col(key_col);
                        end else begin
                            row_idx <= hit_row;
                            col_idx <= hit_col;
                            if (ACCEPT_ON_FIRST) begin
                                key_code  <= {hit_row, hit_col};
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= DEB_W'(1);
                                state   <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (tracked_low) begin
                            if (deb_inc == DEB_MAX) begin
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end else begin
                            // Bounce: drop the candidate silently.
                            deb_cnt <= '0;
                            key_col <= rotate_col(key_col);
                            state   <= SCAN;
                        end
                    end

                    HELD: begin
                        if (!tracked_low) begin
                            if (deb_inc == DEB_MAX) begin
                                key_down <= 1'b0;
                                deb_cnt  <= '0;
                                key_col  <= rotate_col(key_col);
                                state    <= SCAN;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end else begin
                            // A low sample means the release was a glitch.
                            deb_cnt <= '0;
                        end
                    end

                    default: begin
                        deb_cnt <= '0;
                        key_col <= COL_RESET;
                        state   <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_key_matrix_scan
//
// Bench for key_matrix_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3. A small
// matrix model turns the set of pressed keys into row levels from the
// current column drive. Expected key codes are queued when a press is
// issued; a monitor pops and compares on every key_valid strobe.
// ---------------------------------------------------------------------------
module tb_key_matrix_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    // pressed[row][col]
    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;
    logic [3:0] exp_col;

    int compared   = 0;
    int mismatched = 0;

    key_matrix_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // A row goes low when a pressed key in it sits on the driven column.
    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~|(pressed[r] & ~key_col);
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] exp, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_col === exp) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL %s: key_col %b expected %b within %0d cycles", name, key_col, exp, budget);
        end
    endtask

    task automatic applyStimulus(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued code.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_valid: got code %h expected no strobe", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("code_on_valid", key_code, mon_exp);
                checkOutput("down_on_valid", {3'b000, key_down}, 4'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        release_all();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;

        // Reset state
        checkOutput("reset_col",   key_col, 4'b1110);
        checkOutput("reset_code",  key_code, 4'h0);
        checkOutput("reset_valid", {3'b000, key_valid}, 4'h0);
        checkOutput("reset_down",  {3'b000, key_down}, 4'h0);

        // Idle rotation for 20 ticks
        exp_col = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            exp_col = {exp_col[2:0], exp_col[3]};
            wait_col(exp_col, 6, "idle_rotate");
        end

        // Bounce on row0/col0: one low tick only
        applyStimulus(0, 0);
        wait_cycles(4);
        release_all();
        wait_cycles(2);
        checkOutput("bounce_col_frozen", key_col, 4'b1110);
        wait_col(4'b1101, 6, "bounce_resume");
        checkOutput("bounce_down", {3'b000, key_down}, 4'h0);

        // Row1 at col2 held 10 ticks -> code 6
        wait_col(4'b1011, 8, "reach_col2");
        exp_q.push_back(4'h6);
        applyStimulus(1, 2);
        wait_cycles(11);
        checkOutput("press_latency_early", {3'b000, key_valid}, 4'h0);
        wait_cycles(1);
        checkOutput("press_latency_valid", {3'b000, key_valid}, 4'h1);
        wait_cycles(28);
        checkOutput("held_col",  key_col, 4'b1011);
        checkOutput("held_down", {3'b000, key_down}, 4'h1);
        checkOutput("held_code", key_code, 4'h6);
        checkOutput("held_single_pulse", 4'(exp_q.size()), 4'h0);

        // Release with a one-tick glitch low in the middle
        release_all();
        wait_cycles(8);
        applyStimulus(1, 2);
        wait_cycles(4);
        release_all();
        wait_cycles(6);
        checkOutput("release_glitch_down", {3'b000, key_down}, 4'h1);
        checkOutput("release_glitch_col",  key_col, 4'b1011);
        wait_col(4'b0111, 12, "release_resume");
        checkOutput("release_down", {3'b000, key_down}, 4'h0);
        checkOutput("release_code_kept", key_code, 4'h6);

        // Rows 0 and 3 on col3 -> lowest row wins
        exp_q.push_back(4'h3);
        applyStimulus(0, 3);
        applyStimulus(3, 3);
        wait_cycles(20);
        checkOutput("multi_down", {3'b000, key_down}, 4'h1);
        checkOutput("multi_code", key_code, 4'h3);
        release_all();
        wait_col(4'b1110, 24, "multi_release");
        checkOutput("multi_release_down", {3'b000, key_down}, 4'h0);

        // Reset during DEBOUNCE
        wait_col(4'b1101, 8, "reach_col1");
        applyStimulus(2, 1);
        wait_cycles(6);
        checkOutput("pre_reset_col", key_col, 4'b1101);
        rst = 1'b1;
        release_all();
        @(negedge clk);
        checkOutput("mid_reset_col",   key_col, 4'b1110);
        checkOutput("mid_reset_down",  {3'b000, key_down}, 4'h0);
        checkOutput("mid_reset_valid", {3'b000, key_valid}, 4'h0);
        rst = 1'b0;
        wait_cycles(30);

        checkOutput("scoreboard_drained", 4'(exp_q.size()), 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
